// File: rtl/morra_cinese_param.sv
// Rock-paper-scissors ("morra cinese") referee: scores one round per clock edge while a game is
// running. Defining MORRA_PUNTEGGIO_EN adds per-player win counters (vinte_primo, vinte_secondo).
module morra_cinese_param #(
  parameter int MANCHE_BASE   = 4,
  parameter int MANCHE_MIN    = 4,
  parameter int VANTAGGIO_VIT = 2,
  parameter int CNT_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       primo,
  input  logic [1:0]       secondo,
  input  logic             inizia,
  output logic [1:0]       manche,
  output logic [1:0]       partita,
  output logic [CNT_W-1:0] manche_giocate
`ifdef MORRA_PUNTEGGIO_EN
  ,
  output logic [CNT_W-1:0] vinte_primo,
  output logic [CNT_W-1:0] vinte_secondo
`endif
);

  typedef enum logic [1:0] {IDLE = 2'b00, GIOCO = 2'b01, FINE = 2'b10} state_t;

  localparam logic [1:0] NESSUNO = 2'b00;
  localparam logic [1:0] P1      = 2'b01;
  localparam logic [1:0] P2      = 2'b10;
  localparam logic [1:0] PARI    = 2'b11;

  localparam logic signed [CNT_W:0] ADV_ONE = (CNT_W+1)'(1);
  localparam logic signed [CNT_W:0] VANT_P  = (CNT_W+1)'(VANTAGGIO_VIT);
  localparam logic signed [CNT_W:0] VANT_N  = -VANT_P;
  localparam logic [CNT_W-1:0]      MIN_C   = CNT_W'(MANCHE_MIN);
  localparam logic [CNT_W-1:0]      BASE_C  = CNT_W'(MANCHE_BASE);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

  state_t                  state_reg, state_next;
  logic [1:0]              manche_reg, manche_next;
  logic [1:0]              partita_reg, partita_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [CNT_W-1:0]        max_reg, max_next;
  logic signed [CNT_W:0]   adv_reg, adv_next;
  // Move block: which player (P1/P2, NESSUNO = none) may not reuse which winning move.
  logic [1:0]              blk_pl_reg, blk_pl_next;
  logic [1:0]              blk_mv_reg, blk_mv_next;
`ifdef MORRA_PUNTEGGIO_EN
  logic [CNT_W-1:0]        vp_reg, vp_next;
  logic [CNT_W-1:0]        vs_reg, vs_next;
`endif

  logic win1, draw, valid;

  always_comb begin
    win1  = (primo == 2'b01 && secondo == 2'b11) ||
            (primo == 2'b10 && secondo == 2'b01) ||
            (primo == 2'b11 && secondo == 2'b10);
    draw  = (primo == secondo);
    valid = (primo != 2'b00) && (secondo != 2'b00) &&
            !(blk_pl_reg == P1 && primo   == blk_mv_reg) &&
            !(blk_pl_reg == P2 && secondo == blk_mv_reg);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      manche_reg  <= NESSUNO;
      partita_reg <= NESSUNO;
      cnt_reg     <= '0;
      max_reg     <= '0;
      adv_reg     <= '0;
      blk_pl_reg  <= NESSUNO;
      blk_mv_reg  <= 2'b00;
`ifdef MORRA_PUNTEGGIO_EN
      vp_reg      <= '0;
      vs_reg      <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      manche_reg  <= manche_next;
      partita_reg <= partita_next;
      cnt_reg     <= cnt_next;
      max_reg     <= max_next;
      adv_reg     <= adv_next;
      blk_pl_reg  <= blk_pl_next;
      blk_mv_reg  <= blk_mv_next;
`ifdef MORRA_PUNTEGGIO_EN
      vp_reg      <= vp_next;
      vs_reg      <= vs_next;
`endif
    end
  end

  // Next-state logic; termination tests the just-updated count and advantage
  always_comb begin
    state_next   = state_reg;
    manche_next  = NESSUNO;
    partita_next = partita_reg;
    cnt_next     = cnt_reg;
    max_next     = max_reg;
    adv_next     = adv_reg;
    blk_pl_next  = blk_pl_reg;
    blk_mv_next  = blk_mv_reg;
`ifdef MORRA_PUNTEGGIO_EN
    vp_next      = vp_reg;
    vs_next      = vs_reg;
`endif
    if (inizia) begin
      state_next   = GIOCO;
      partita_next = NESSUNO;
      cnt_next     = '0;
      max_next     = BASE_C + CNT_W'({primo, secondo});
      adv_next     = '0;
      blk_pl_next  = NESSUNO;
      blk_mv_next  = 2'b00;
`ifdef MORRA_PUNTEGGIO_EN
      vp_next      = '0;
      vs_next      = '0;
`endif
    end else if (state_reg == GIOCO && valid) begin
      cnt_next = cnt_reg + CNT_ONE;
      if (draw) begin
        manche_next = PARI;
        blk_pl_next = NESSUNO;
        blk_mv_next = 2'b00;
      end else if (win1) begin
        manche_next = P1;
        adv_next    = adv_reg + ADV_ONE;
        blk_pl_next = P1;
        blk_mv_next = primo;
`ifdef MORRA_PUNTEGGIO_EN
        vp_next     = vp_reg + CNT_ONE;
`endif
      end else begin
        manche_next = P2;
        adv_next    = adv_reg - ADV_ONE;
        blk_pl_next = P2;
        blk_mv_next = secondo;
`ifdef MORRA_PUNTEGGIO_EN
        vs_next     = vs_reg + CNT_ONE;
`endif
      end
      if (cnt_next >= MIN_C && (adv_next >= VANT_P || adv_next <= VANT_N)) begin
        partita_next = (adv_next > 0) ? P1 : P2;
        state_next   = FINE;
      end else if (cnt_next == max_reg) begin
        partita_next = (adv_next > 0) ? P1 : (adv_next < 0) ? P2 : PARI;
        state_next   = FINE;
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    manche         = manche_reg;
    partita        = partita_reg;
    manche_giocate = cnt_reg;
`ifdef MORRA_PUNTEGGIO_EN
    vinte_primo    = vp_reg;
    vinte_secondo  = vs_reg;
`endif
  end

endmodule

// File: tb/tb_morra_cinese_param.sv
// Directed bench for morra_cinese_param; define MORRA_PUNTEGGIO_EN to also check the win counters.
module tb_morra_cinese_param;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       primo = 2'b00;
  logic [1:0]       secondo = 2'b00;
  logic             inizia = 1'b0;
  logic [1:0]       manche;
  logic [1:0]       partita;
  logic [CNT_W-1:0] manche_giocate;
`ifdef MORRA_PUNTEGGIO_EN
  logic [CNT_W-1:0] vinte_primo;
  logic [CNT_W-1:0] vinte_secondo;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  morra_cinese_param #(
    .MANCHE_BASE(4), .MANCHE_MIN(4), .VANTAGGIO_VIT(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .primo(primo),
    .secondo(secondo),
    .inizia(inizia),
    .manche(manche),
    .partita(partita),
    .manche_giocate(manche_giocate)
`ifdef MORRA_PUNTEGGIO_EN
    ,
    .vinte_primo(vinte_primo),
    .vinte_secondo(vinte_secondo)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transaction: drive at negedge, sample 1 time unit after the rising edge
  task automatic step(input logic i, input logic [1:0] p, input logic [1:0] s,
                      input string tag, input int em, input int ep, input int ec);
    @(negedge clk);
    inizia = i; primo = p; secondo = s;
    @(posedge clk);
    #1;
    $display("%s: inizia=%0b primo=%02b secondo=%02b -> manche=%02b partita=%02b giocate=%0d",
             tag, i, p, s, manche, partita, manche_giocate);
    check({tag, ".manche"},  32'(manche),         32'(em));
    check({tag, ".partita"}, 32'(partita),        32'(ep));
    check({tag, ".giocate"}, 32'(manche_giocate), 32'(ec));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.manche", 32'(manche), 0);
    check("rst.partita", 32'(partita), 0);
    check("rst.giocate", 32'(manche_giocate), 0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores moves
    step(0, 2'b01, 2'b11, "idle", 0, 0, 0);

    // inizia has priority; max = 4 + 7 = 11
    step(1, 2'b01, 2'b11, "start7", 0, 0, 0);
    step(0, 2'b00, 2'b10, "nomove", 0, 0, 0);
    step(0, 2'b01, 2'b11, "win1", 1, 0, 1);
    for (int k = 2; k <= 10; k++) step(0, 2'b10, 2'b10, "draw_pre", 3, 0, k);
    step(0, 2'b10, 2'b10, "draw_max11", 3, 1, 11);

    // Early win by advantage with max 4
    step(1, 2'b00, 2'b00, "start0", 0, 0, 0);
    step(0, 2'b01, 2'b11, "ew1", 1, 0, 1);
    step(0, 2'b10, 2'b01, "ew2", 1, 0, 2);
    step(0, 2'b11, 2'b10, "ew3", 1, 0, 3);
    step(0, 2'b01, 2'b11, "ew4", 1, 1, 4);
`ifdef MORRA_PUNTEGGIO_EN
    check("ew.vinte_primo", 32'(vinte_primo), 4);
    check("ew.vinte_secondo", 32'(vinte_secondo), 0);
`endif
    step(0, 2'b10, 2'b01, "fine_hold", 0, 1, 4);

    // Move block for both players
    step(1, 2'b00, 2'b00, "blk_start", 0, 0, 0);
    step(0, 2'b01, 2'b11, "blk1", 1, 0, 1);
    step(0, 2'b01, 2'b11, "blk_rep1", 0, 0, 1);
    step(0, 2'b10, 2'b01, "blk2", 1, 0, 2);
    step(0, 2'b11, 2'b01, "blk_p2win", 2, 0, 3);
    step(0, 2'b11, 2'b01, "blk_rep2", 0, 0, 3);

    // Draw reaching the limit, max = 5
    step(1, 2'b00, 2'b01, "dl_start", 0, 0, 0);
    for (int k = 1; k <= 4; k++) step(0, 2'b01, 2'b01, "dl_draw", 3, 0, k);
    step(0, 2'b01, 2'b01, "dl_draw5", 3, 3, 5);
    step(0, 2'b01, 2'b11, "dl_after", 0, 3, 5);

    // Player 2 leads by 3 after round 3 but cannot win before round 4; max = 19
    step(1, 2'b11, 2'b11, "p2_start", 0, 0, 0);
    step(0, 2'b11, 2'b01, "p2w1", 2, 0, 1);
    step(0, 2'b10, 2'b11, "p2w2", 2, 0, 2);
    step(0, 2'b01, 2'b10, "p2w3", 2, 0, 3);
    step(0, 2'b11, 2'b01, "p2w4", 2, 2, 4);
`ifdef MORRA_PUNTEGGIO_EN
    check("p2.vinte_primo", 32'(vinte_primo), 0);
    check("p2.vinte_secondo", 32'(vinte_secondo), 4);
`endif

    // Asynchronous reset mid-game
    step(1, 2'b00, 2'b00, "rm_start", 0, 0, 0);
    step(0, 2'b01, 2'b11, "rm1", 1, 0, 1);
    step(0, 2'b10, 2'b01, "rm2", 1, 0, 2);
    #2 rst = 1'b1;
    #1;
    $display("async reset: manche=%02b partita=%02b giocate=%0d", manche, partita, manche_giocate);
    check("rm.manche", 32'(manche), 0);
    check("rm.partita", 32'(partita), 0);
    check("rm.giocate", 32'(manche_giocate), 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 2'b11, 2'b10, "rm_ignored", 0, 0, 0);
    step(1, 2'b00, 2'b00, "rm_restart", 0, 0, 0);
    step(0, 2'b11, 2'b10, "rm_play", 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
